wb_dma_sequencer: RTL
=====================

// Module: wb_dma_sequencer
// PURPOSE
//  Word-copy engine that sits directly upstream of wb_master_interface and drives its
//  start/address/selection/write/data_wr command port. It reads word_count 32-bit words
//  from src_addr and writes each one to dst_addr, one word at a time. Completion of each
//  transaction is taken from the master's active/data_rd outputs.
//  Used by the DSP/DAQ path to move sample blocks between RAM0..RAM3 over the bus matrix.
// PARAMETERS
//  CW        16   width of word_count and words_done (max 2^CW-1 words per job)
//  ADDR_INC  4    byte increment applied to src/dst pointers after each word
// PORTS
//  wb_clk      in   1    system clock
//  wb_rst_n    in   1    reset, asynchronous, active-low
//  go          in   1    1-cycle job start; sampled only in IDLE
//  abort       in   1    level; stop the job after the in-flight bus transaction
//  src_addr    in   32   source byte address (bits[1:0] forced to 0)
//  dst_addr    in   32   destination byte address (bits[1:0] forced to 0)
//  word_count  in   CW   number of words to copy
//  busy        out  1    job in progress
//  done        out  1    1-cycle pulse at job end (normal or aborted)
//  aborted     out  1    valid with done; 1 = job ended by abort
//  words_done  out  CW   words fully written in the current/last job
//  start       out  1    to master: 1-cycle transaction request
//  address     out  32   to master: byte address
//  selection   out  4    to master: byte lanes, always 4'hF
//  write       out  1    to master: 1 = write, 0 = read
//  data_wr     out  32   to master: write data
//  data_rd     in   32   from master: read data, valid when active falls after a read
//  active      in   1    from master: transaction in flight
//  checksum    out  32   only with DMA_CHECKSUM_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE. busy, done, aborted, start, write = 0. address, data_wr,
//   words_done = 0. selection = 4'hF.
//  Reset mid-job: drop to IDLE immediately, with no done pulse; the master is reset separately.
//  go in IDLE: latch src/dst (bits[1:0] cleared) and word_count; clear words_done; busy=1 next cycle.
//   If word_count==0, go straight to FIN: done=1 one cycle after go, no bus traffic.
//  go while busy: ignored.
//  States:
//   IDLE
//   RD_ISSUE: hold while active==1. Otherwise start=1 and write=0 for exactly one cycle,
//    address=src -> RD_ARM.
//   RD_ARM: wait for active==1 -> RD_WAIT.
//   RD_WAIT: on active==0, capture data_rd into data_wr -> WR_ISSUE.
//   WR_ISSUE: hold while active==1. Otherwise start=1 and write=1 for one cycle,
//    address=dst -> WR_ARM.
//   WR_ARM: wait for active==1 -> WR_WAIT.
//   WR_WAIT: on active==0 -> NEXT.
//   NEXT: words_done+1; src+=ADDR_INC; dst+=ADDR_INC.
//    If words_done+1==count or abort==1 -> FIN, else -> RD_ISSUE.
//   FIN: done=1 and busy=0 for one cycle; aborted=abort_seen -> IDLE.
//  start is never high for two consecutive cycles; write/address/data_wr are stable
//   while start=1.
//  abort: latched into abort_seen in any busy state. The current read+write pair
//   always completes, so a word is never half-copied. FIN follows the next NEXT.
//  Address arithmetic is modulo 2^32; no carry out; wrap past 0xFFFFFFFC is permitted.
//  Throughput: at least 6 cycles per word; 1 cycle go->busy.
// CONFIGURATION
//  DMA_CHECKSUM_EN defined: checksum = modulo-2^32 sum of every word captured in RD_WAIT.
//   Cleared to 0 on accepted go; held after FIN until the next go; reset value 0.
//  Not defined: no checksum port and no adder logic.
// TESTING
//  1 Copy: preload RAM0 0x20000000=a5a5b6b6, 0x20000004=01234567. Run go, src=0x20000000,
//    dst=0x30000000, count=2 -> one done pulse, aborted=0, words_done=2,
//    RAM1 reads back a5a5b6b6/01234567, exactly 4 start pulses.
//  2 Zero count: count=0 -> done one cycle after go, no start pulse, words_done=0.
//  3 Abort: count=8 RAM1->RAM2, abort after 2nd write start -> done with aborted=1,
//    words_done=2, RAM2 words 0-1 copied, word 2 unchanged.
//  4 go while busy: second go mid-job with a different src -> ignored; first job is
//    unaffected; exactly one done.
//  5 Reset mid-job: drive wb_rst_n low during RD_WAIT -> all outputs return to reset
//    values asynchronously, no done; a fresh count=1 job then completes normally.
//  6 DMA_CHECKSUM_EN: copy 3 words 1,2,0xFFFFFFFF -> checksum=0x00000002 after done.

Source files
------------

// File: rtl/wb_dma_sequencer.sv
// wb_dma_sequencer
//   Word-copy engine placed directly upstream of wb_master_interface. A job copies
//   word_count 32-bit words from src_addr to dst_addr, one read+write pair at a time,
//   driving the master's command port (start/address/selection/write/data_wr) and
//   tracking completion through the master's active/data_rd outputs.
//
// Parameters
//   CW        width of word_count / words_done
//   ADDR_INC  byte increment applied to both pointers after every copied word
//
// Ports
//   wb_clk, wb_rst_n        clock, asynchronous active-low reset
//   go, abort               job start (sampled in IDLE only) / level stop request
//   src_addr, dst_addr      byte addresses, bits[1:0] ignored
//   word_count              words to copy
//   busy, done, aborted     job status; done is a 1-cycle pulse, aborted valid with done
//   words_done              words fully written in the current/last job
//   start, address,
//   selection, write,
//   data_wr                 command port to the master
//   data_rd, active         response from the master
//   checksum                sum of all words read (only with DMA_CHECKSUM_EN)
//
// Optional feature
//   `define DMA_CHECKSUM_EN adds the checksum port and its accumulator.

module wb_dma_sequencer #(
  parameter int CW       = 16,
  parameter int ADDR_INC = 4
) (
  input  logic          wb_clk,
  input  logic          wb_rst_n,
  input  logic          go,
  input  logic          abort,
  input  logic [31:0]   src_addr,
  input  logic [31:0]   dst_addr,
  input  logic [CW-1:0] word_count,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic [CW-1:0] words_done,
  output logic          start,
  output logic [31:0]   address,
  output logic [3:0]    selection,
  output logic          write,
  output logic [31:0]   data_wr,
  input  logic [31:0]   data_rd,
  input  logic          active
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [31:0]   checksum
`endif
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_ARM,
    S_RD_WAIT,
    S_WR_ISSUE,
    S_WR_ARM,
    S_WR_WAIT,
    S_NEXT,
    S_FIN
  } state_t;

  localparam logic [31:0] INC = 32'(ADDR_INC);

  state_t        state_q, state_d;
  logic [31:0]   src_q;
  logic [31:0]   dst_q;
  logic [CW-1:0] count_q;
  logic          abort_seen;
  logic [CW-1:0] words_inc;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

  assign selection = 4'hF;
  assign words_inc = words_done + CW'(1);

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    aborted = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go) state_d = (word_count == '0) ? S_FIN : S_RD_ISSUE;
      end
      S_RD_ISSUE: begin
        busy = 1'b1;
        if (!active) state_d = S_RD_ARM;
      end
      S_RD_ARM: begin
        busy = 1'b1;
        if (active) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        busy = 1'b1;
        if (!active) state_d = S_WR_ISSUE;
      end
      S_WR_ISSUE: begin
        busy = 1'b1;
        if (!active) state_d = S_WR_ARM;
      end
      S_WR_ARM: begin
        busy = 1'b1;
        if (active) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        busy = 1'b1;
        if (!active) state_d = S_NEXT;
      end
      S_NEXT: begin
        busy = 1'b1;
        // A live abort is honoured here as well as a latched one, so the job
        // never starts another read once abort has been seen.
        if ((words_inc == count_q) || abort || abort_seen) state_d = S_FIN;
        else                                                  state_d = S_RD_ISSUE;
      end
      S_FIN: begin
        done    = 1'b1;
        aborted = abort_seen;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Command port and job bookkeeping. start is registered, so it is high for the
  // single cycle after the issue state saw the master idle; address/write/data_wr
  // change only on that same edge and are therefore stable while start is high.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      start      <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      data_wr    <= '0;
      words_done <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      count_q    <= '0;
      abort_seen <= 1'b0;
    end else begin
      start <= 1'b0;
      if (busy && abort) abort_seen <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (go) begin
            src_q      <= word_align(src_addr);
            dst_q      <= word_align(dst_addr);
            count_q    <= word_count;
            words_done <= '0;
            abort_seen <= 1'b0;
          end
        end
        S_RD_ISSUE: begin
          if (!active) begin
            start   <= 1'b1;
            write   <= 1'b0;
            address <= src_q;
          end
        end
        S_RD_WAIT: begin
          if (!active) data_wr <= data_rd;
        end
        S_WR_ISSUE: begin
          if (!active) begin
            start   <= 1'b1;
            write   <= 1'b1;
            address <= dst_q;
          end
        end
        S_NEXT: begin
          words_done <= words_inc;
          src_q      <= src_q + INC;
          dst_q      <= dst_q + INC;
        end
        default: ;
      endcase
    end
  end

`ifdef DMA_CHECKSUM_EN
  // Accumulates exactly the words latched into data_wr.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      checksum <= '0;
    end else if (state_q == S_IDLE && go) begin
      checksum <= '0;
    end else if (state_q == S_RD_WAIT && !active) begin
      checksum <= checksum + data_rd;
    end
  end
`endif

endmodule
